// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - set-associative icache refill, drain and flush sequencer
module icache_refill_ctrl #(
    parameter int NUM_WAYS       = 2,
    parameter int BEATS_PER_LINE = 4,
    parameter int NUM_SETS       = 64,
    localparam int BEAT_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1,
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int SET_W  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if2icache_req_i,
    input  logic                if2icache_req_kill_i,
    input  logic                imem_sel_i,
    input  logic [NUM_WAYS-1:0] hit_way_i,
    output logic                icache2if_ack_o,
    input  logic                flush_i,
    output logic                flush_busy_o,
    output logic                icache2mem_req_o,
    input  logic                mem2icache_ack_i,
    output logic                cache_we_o,
    output logic [WAY_W-1:0]    cache_way_o,
    output logic [BEAT_W-1:0]   refill_beat_o,
    output logic                cache_valid_set_o,
    output logic                cache_valid_clr_o,
    output logic [SET_W-1:0]    flush_set_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic              pend_q, pend_d;
    logic              ack_q, ack_d;

    logic any_hit;
    logic lookup_ok;
    logic hit;
    logic miss;
    logic last_beat;
    logic last_set;
    logic [WAY_W-1:0] victim_next;

    assign any_hit      = |hit_way_i;
    assign flush_busy_o = pend_q | (state_q == ST_FLUSH);
    assign lookup_ok    = if2icache_req_i & imem_sel_i & (state_q == ST_IDLE) & ~flush_busy_o;
    assign hit          = lookup_ok & any_hit;
    assign miss         = lookup_ok & ~any_hit;
    assign ack_d        = hit & ~if2icache_req_kill_i;
    assign last_beat    = (beat_q == BEAT_W'(BEATS_PER_LINE - 1));
    assign last_set     = (set_q == SET_W'(NUM_SETS - 1));
    // A direct-mapped cache has a single way, so the pointer never moves.
    assign victim_next  = (NUM_WAYS > 1) ? victim_q + WAY_W'(1) : '0;

    always_comb begin
        state_d           = state_q;
        beat_d            = beat_q;
        set_d             = set_q;
        victim_d          = victim_q;
        way_d             = way_q;
        pend_d            = pend_q | (flush_i & (state_q != ST_FLUSH));
        icache2mem_req_o  = 1'b0;
        cache_we_o        = 1'b0;
        cache_valid_set_o = 1'b0;
        cache_valid_clr_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_FLUSH;
                end else if (miss && !if2icache_req_kill_i) begin
                    state_d = ST_REFILL;
                    way_d   = victim_q;
                end
            end
            ST_REFILL: begin
                icache2mem_req_o = 1'b1;
                if (mem2icache_ack_i) begin
                    cache_we_o = 1'b1;
                    if (last_beat) begin
                        cache_valid_set_o = 1'b1;
                        beat_d            = '0;
                        victim_d          = victim_next;
                        state_d           = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
                // Memory cannot abort a line read, so a redirect only stops the writes.
                if ((if2icache_req_kill_i || !imem_sel_i) && !(mem2icache_ack_i && last_beat)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                icache2mem_req_o = 1'b1;
                if (mem2icache_ack_i) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                cache_valid_clr_o = 1'b1;
                if (last_set) begin
                    set_d   = '0;
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            set_q    <= '0;
            victim_q <= '0;
            way_q    <= '0;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            set_q    <= set_d;
            victim_q <= victim_d;
            way_q    <= way_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
        end
    end

    assign icache2if_ack_o = ack_q;
    assign cache_way_o     = way_q;
    assign refill_beat_o   = beat_q;
    assign flush_set_o     = set_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req, kill, sel, flush, mack;
    logic [1:0] hw;
    logic       ack_o, busy_o, mreq_o, we_o, vset_o, vclr_o;
    logic       way_o;
    logic [1:0] beat_o;
    logic [5:0] fset_o;
    int         n_chk;
    int         n_pass;

    icache_refill_ctrl dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .if2icache_req_i      (req),
        .if2icache_req_kill_i (kill),
        .imem_sel_i           (sel),
        .hit_way_i            (hw),
        .icache2if_ack_o      (ack_o),
        .flush_i              (flush),
        .flush_busy_o         (busy_o),
        .icache2mem_req_o     (mreq_o),
        .mem2icache_ack_i     (mack),
        .cache_we_o           (we_o),
        .cache_way_o          (way_o),
        .refill_beat_o        (beat_o),
        .cache_valid_set_o    (vset_o),
        .cache_valid_clr_o    (vclr_o),
        .flush_set_o          (fset_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input logic rq, input logic kl, input logic sl, input logic [1:0] h,
                       input logic fl, input logic ma);
        @(negedge clk);
        req = rq; kill = kl; sel = sl; hw = h; flush = fl; mack = ma;
        #1;
    endtask

    task automatic do_refill(input logic w);
        cyc(1, 0, 1, 2'b00, 0, 0);
        chk("miss_cycle_no_req", mreq_o, 0);
        for (int b = 0; b < 4; b++) begin
            cyc(0, 0, 1, 2'b00, 0, 1);
            chk("refill_req", mreq_o, 1);
            chk("refill_we", we_o, 1);
            chk("refill_beat", beat_o, b);
            chk("refill_way", way_o, w);
            chk("refill_vset", vset_o, (b == 3) ? 1 : 0);
        end
        cyc(0, 0, 0, 2'b00, 0, 0);
        chk("refill_done_idle", mreq_o, 0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        req = 0; kill = 0; sel = 0; hw = 0; flush = 0; mack = 0;
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_ack", ack_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_mreq", mreq_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_way", way_o, 0);
        chk("rst_beat", beat_o, 0);
        chk("rst_vset", vset_o, 0);
        chk("rst_vclr", vclr_o, 0);
        chk("rst_fset", fset_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // hit on way 1 acknowledged one cycle later, no memory activity
        cyc(1, 0, 1, 2'b10, 0, 0);
        chk("hit_ack_not_yet", ack_o, 0);
        chk("hit_no_mreq", mreq_o, 0);
        cyc(0, 0, 0, 2'b00, 0, 0);
        chk("hit_ack", ack_o, 1);
        chk("hit_no_mreq2", mreq_o, 0);
        cyc(1, 1, 1, 2'b01, 0, 0);
        chk("ack_drop", ack_o, 0);
        cyc(0, 0, 0, 2'b00, 0, 0);
        chk("killed_hit_no_ack", ack_o, 0);

        // round-robin victims across three refills
        do_refill(0);
        do_refill(1);
        do_refill(0);

        // kill after two beats: remaining beats drained without writes
        cyc(1, 0, 1, 2'b00, 0, 0);
        for (int b = 0; b < 2; b++) begin
            cyc(0, 0, 1, 2'b00, 0, 1);
            chk("kill_pre_we", we_o, 1);
            chk("kill_pre_way", way_o, 1);
        end
        cyc(0, 1, 1, 2'b00, 0, 0);
        chk("kill_cycle_mreq", mreq_o, 1);
        chk("kill_cycle_we", we_o, 0);
        for (int b = 2; b < 4; b++) begin
            cyc(0, 0, 1, 2'b00, 0, 1);
            chk("drain_mreq", mreq_o, 1);
            chk("drain_we", we_o, 0);
            chk("drain_vset", vset_o, 0);
            chk("drain_beat", beat_o, b);
        end
        cyc(0, 0, 1, 2'b00, 0, 0);
        chk("drain_idle", mreq_o, 0);
        do_refill(1);

        // flush pulsed with beat 1 of a refill is deferred until the line completes
        cyc(1, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 1, 2'b00, 0, 1);
        chk("fl_beat0_we", we_o, 1);
        chk("fl_busy_before", busy_o, 0);
        cyc(0, 0, 1, 2'b00, 1, 1);
        chk("fl_beat1_we", we_o, 1);
        cyc(0, 0, 1, 2'b00, 0, 1);
        chk("fl_busy_beat2", busy_o, 1);
        chk("fl_beat2_we", we_o, 1);
        cyc(0, 0, 1, 2'b00, 0, 1);
        chk("fl_beat3_vset", vset_o, 1);
        chk("fl_beat3_way", way_o, 0);
        cyc(1, 0, 1, 2'b01, 0, 0);
        chk("fl_idle_busy", busy_o, 1);
        chk("fl_idle_no_clr", vclr_o, 0);
        chk("fl_idle_no_mreq", mreq_o, 0);
        for (int s = 0; s < 64; s++) begin
            cyc(1, 0, 1, 2'b01, (s == 10) ? 1'b1 : 1'b0, 0);
            chk("flush_clr", vclr_o, 1);
            chk("flush_set", fset_o, s);
            chk("flush_busy", busy_o, 1);
            chk("flush_no_ack", ack_o, 0);
        end
        cyc(1, 0, 1, 2'b01, 0, 0);
        chk("post_flush_clr", vclr_o, 0);
        chk("post_flush_busy", busy_o, 0);
        chk("post_flush_no_ack", ack_o, 0);
        cyc(0, 0, 0, 2'b00, 0, 0);
        chk("post_flush_hit_ack", ack_o, 1);
        chk("post_flush_fset", fset_o, 0);

        // miss with same-cycle kill, then a miss outside imem
        cyc(1, 1, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 2'b00, 0, 0);
        chk("kill_miss_no_req", mreq_o, 0);
        cyc(1, 0, 0, 2'b00, 0, 0);
        cyc(0, 0, 0, 2'b00, 0, 0);
        chk("nosel_no_req", mreq_o, 0);
        chk("nosel_no_ack", ack_o, 0);

        // asynchronous reset in the middle of a refill into way 1
        cyc(1, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 1, 2'b00, 0, 1);
        chk("pre_rst_way", way_o, 1);
        cyc(0, 0, 1, 2'b00, 0, 1);
        chk("pre_rst_beat", beat_o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_mreq", mreq_o, 0);
        chk("arst_we", we_o, 0);
        chk("arst_way", way_o, 0);
        chk("arst_beat", beat_o, 0);
        chk("arst_vset", vset_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_refill(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
